com_valid_rx: RTL and testbench
===============================

# com_valid_rx

Receive-side counterpart of the PHY COM/valid conditioner. It samples the 8-bit lane stream on `cclk` and acquires symbol lock after a run of consecutive COM symbols (8'hBC). Once locked, it strips COM fillers and regenerates a per-byte valid strobe with registered data for the link layer. It sits in the PHY receive path, after the lane deserializer and before the receive FIFO.

## Interface

Parameters:
- `COM_SYMBOL`, 8'hBC: filler/idle symbol inserted by the transmitter when it has no valid data.
- `COM_LOCK`, 4: number of consecutive COM symbols required to acquire lock; legal range 1..15.

Ports:
- `cclk`  input  1  sole clock; all state updates on the rising edge.
- `default_values`  input  1  synchronous, active-high reset.
- `data_in`  input  8  lane byte, sampled every `cclk` rising edge.
- `data_out`  output  8  recovered data byte, registered.
- `valid_out`  output  1  high for exactly the cycles in which `data_out` carries a newly received data byte.
- `active`  output  1  symbol lock indicator; high while in ACTIVE.
- `byte_count`  output  16  received-byte counter; exists only under `COM_RX_BYTE_COUNT_EN`.

## Operation

- Two-state FSM: SEARCH (reset state) and ACTIVE. No other exit from ACTIVE exists; the only way back to SEARCH is `default_values`.
- 4-bit `com_run` counter, reset 0.
- SEARCH, `data_in == COM_SYMBOL`:
  - if `com_run == COM_LOCK-1`: go to ACTIVE and clear `com_run`;
  - otherwise increment `com_run`.
- SEARCH, `data_in != COM_SYMBOL`: clear `com_run` and stay in SEARCH. The byte is discarded: `valid_out` is 0 and `data_out` is unchanged.
- ACTIVE, `data_in != COM_SYMBOL`: `data_out <= data_in`, `valid_out <= 1`.
- ACTIVE, `data_in == COM_SYMBOL`: `valid_out <= 0` and `data_out` holds its previous value. A COM byte is never presented as data.
- `COM_LOCK = 1`: a single COM acquires lock.
- `com_run` never exceeds `COM_LOCK-1`, so no overflow is possible.

## Timing

- Every output is registered and updates on the `cclk` rising edge.
- Latency from `data_in` to `data_out`/`valid_out` is 1 cycle.
- Lock timing:
  - `active` rises on the same edge that samples the `COM_LOCK`-th consecutive COM.
  - The byte sampled on the next edge is the first one eligible for `valid_out`.
- `valid_out` is never high in a cycle in which `active` is low.
- Outputs while `default_values` is high (effective at the next edge), and their values after reset:
  - `data_out = 8'h00`, `valid_out = 0`, `active = 0`;
  - FSM = SEARCH, `com_run = 0`;
  - `byte_count = 0` when that port is compiled in.
- Reset asserted mid-stream:
  - Reset overrides all other activity on that edge; lock is lost immediately.
  - The next `data_in` after reset deassertion is treated as the first SEARCH sample.
- There is no backpressure. The downstream consumer must accept one byte per `cclk` whenever `valid_out` is high.

## Configuration

- Macro: `COM_RX_BYTE_COUNT_EN`.
- Defined:
  - adds output `byte_count[15:0]`;
  - increments on every edge where `valid_out` is set to 1, i.e. once per delivered data byte;
  - wraps from 16'hFFFF to 16'h0000 with no sticky flag;
  - cleared only by `default_values`.
- Undefined: the port and counter logic are absent. All other behaviour is identical.

## Test plan

- **Reset:** hold `default_values` high for 2 cycles with `data_in = 8'h55` -> `data_out = 8'h00`, `valid_out = 0`, `active = 0` (and `byte_count = 0` if enabled).
- **Lock acquisition:** default `COM_LOCK = 4`, drive BC,BC,BC,12 then BC×4 then 3A -> no lock after the broken run. `active` rises on the edge sampling the 4th BC of the second run, and the next cycle shows `data_out = 8'h3A`, `valid_out = 1`.
- **Stripping and gaps:** locked, drive 01,BC,BC,02,03 -> `valid_out` sequence 1,0,0,1,1 with `data_out` 01,01,01,02,03. `data_out` holds 01 through the COM gap.
- **Pre-lock data ignored:** from reset drive 77,88,99 -> `valid_out` stays 0, `data_out` stays 00, `active` stays 0.
- **Reset mid-stream:** locked and streaming, assert `default_values` for 1 cycle, then drive AA -> `active = 0`, `valid_out = 0` and AA is not delivered. Four subsequent BC bytes relock.
- **Counter wrap (`COM_RX_BYTE_COUNT_EN`):** lock, then stream 65537 non-COM bytes -> `byte_count` reads 16'h0001. With BC inserted between bytes, the count is unchanged by the BC cycles.

Source files
------------

// File: rtl/com_valid_rx.sv
// Receive-side COM/valid conditioner: acquires symbol lock on a run of COM symbols,
// then strips COM fillers and emits registered data with a per-byte valid strobe.
// Optional received-byte counter is compiled in with `COM_RX_BYTE_COUNT_EN.
module com_valid_rx #(
  parameter logic [7:0]  COM_SYMBOL = 8'hBC,
  parameter int unsigned COM_LOCK   = 4
) (
  input  logic        cclk,
  input  logic        default_values,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        valid_out,
`ifdef COM_RX_BYTE_COUNT_EN
  output logic [15:0] byte_count,
`endif
  output logic        active
);

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic [3:0] LOCK_LAST = 4'(COM_LOCK - 1);

  state_t     state_r;
  state_t     state_s;
  logic [3:0] com_run_r;
  logic [3:0] com_run_s;
  logic [7:0] data_s;
  logic       valid_s;
  logic       is_com_s;

  assign is_com_s = (data_in == COM_SYMBOL);
  assign active   = (state_r == ACTIVE);

  // Lock search, COM stripping and next-output selection.
  always_comb begin
    state_s   = state_r;
    com_run_s = com_run_r;
    data_s    = data_out;
    valid_s   = 1'b0;
    case (state_r)
      SEARCH: begin
        if (is_com_s) begin
          if (com_run_r == LOCK_LAST) begin
            state_s   = ACTIVE;
            com_run_s = 4'd0;
          end else begin
            com_run_s = com_run_r + 4'd1;
          end
        end else begin
          com_run_s = 4'd0;
        end
      end
      ACTIVE: begin
        if (is_com_s) begin
          valid_s = 1'b0;
        end else begin
          data_s  = data_in;
          valid_s = 1'b1;
        end
      end
      default: begin
        state_s   = SEARCH;
        com_run_s = 4'd0;
      end
    endcase
  end

  // State, run counter and registered outputs.
  always_ff @(posedge cclk) begin
    if (default_values) begin
      state_r   <= SEARCH;
      com_run_r <= 4'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
    end else begin
      state_r   <= state_s;
      com_run_r <= com_run_s;
      data_out  <= data_s;
      valid_out <= valid_s;
    end
  end

`ifdef COM_RX_BYTE_COUNT_EN
  // Delivered-byte counter; wraps silently at 16 bits.
  always_ff @(posedge cclk) begin
    if (default_values) begin
      byte_count <= 16'h0000;
    end else if (valid_s) begin
      byte_count <= byte_count + 16'h0001;
    end else begin
      byte_count <= byte_count;
    end
  end
`endif

endmodule

// File: tb/tb_com_valid_rx.sv
// Randomized scoreboard bench for com_valid_rx: two instances (COM_LOCK=4 and 1)
// share one stimulus stream and are compared each cycle against a reference model.
module tb_com_valid_rx;

  localparam logic [7:0] COM = 8'hBC;

  typedef struct packed {
    logic        act;
    logic        vld;
    logic [7:0]  dat;
    logic [15:0] cnt;
  } exp_t;

  logic        cclk = 1'b0;
  logic        default_values = 1'b1;
  logic [7:0]  data_in = 8'h55;
  logic [7:0]  data_out0, data_out1;
  logic        valid_out0, valid_out1, active0, active1;
  logic [15:0] byte_count0, byte_count1;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  // reference model state, one slot per instance
  int          lock_len [2] = '{4, 1};
  int          run      [2] = '{0, 0};
  bit          locked   [2] = '{1'b0, 1'b0};
  logic [7:0]  last     [2] = '{8'h00, 8'h00};
  bit          vld      [2] = '{1'b0, 1'b0};
  int          cnt      [2] = '{0, 0};

  always #5 cclk = ~cclk;

`ifndef COM_RX_BYTE_COUNT_EN
  assign byte_count0 = 16'h0000;
  assign byte_count1 = 16'h0000;
`endif

  com_valid_rx #(.COM_SYMBOL(8'hBC), .COM_LOCK(4)) u_dut0 (
    .cclk(cclk), .default_values(default_values), .data_in(data_in),
    .data_out(data_out0), .valid_out(valid_out0),
`ifdef COM_RX_BYTE_COUNT_EN
    .byte_count(byte_count0),
`endif
    .active(active0)
  );

  com_valid_rx #(.COM_SYMBOL(8'hBC), .COM_LOCK(1)) u_dut1 (
    .cclk(cclk), .default_values(default_values), .data_in(data_in),
    .data_out(data_out1), .valid_out(valid_out1),
`ifdef COM_RX_BYTE_COUNT_EN
    .byte_count(byte_count1),
`endif
    .active(active1)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one input byte and push the expected post-edge outputs of both instances.
  task automatic step(input logic rst, input logic [7:0] d);
    exp_t e;
    @(posedge cclk);
    #2;
    default_values = rst;
    data_in        = d;
    for (int k = 0; k < 2; k++) begin
      vld[k] = 1'b0;
      if (rst) begin
        run[k] = 0; locked[k] = 1'b0; last[k] = 8'h00; cnt[k] = 0;
      end else if (!locked[k]) begin
        if (d == COM) begin
          run[k]++;
          if (run[k] == lock_len[k]) begin
            locked[k] = 1'b1;
            run[k]    = 0;
          end
        end else begin
          run[k] = 0;
        end
      end else if (d != COM) begin
        last[k] = d;
        vld[k]  = 1'b1;
        cnt[k]  = (cnt[k] + 1) % 65536;
      end
      e.act = locked[k];
      e.vld = vld[k];
      e.dat = last[k];
      e.cnt = 16'(cnt[k]);
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  function automatic logic [7:0] rand_data();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == COM) b = 8'h00;
    return b;
  endfunction

  // Monitor: compare every presented output cycle against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge cclk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("active0", {15'd0, active0}, {15'd0, e.act});
        chk("valid0", {15'd0, valid_out0}, {15'd0, e.vld});
        chk("data0", {8'd0, data_out0}, {8'd0, e.dat});
`ifdef COM_RX_BYTE_COUNT_EN
        chk("count0", byte_count0, e.cnt);
`endif
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("active1", {15'd0, active1}, {15'd0, e.act});
        chk("valid1", {15'd0, valid_out1}, {15'd0, e.vld});
        chk("data1", {8'd0, data_out1}, {8'd0, e.dat});
`ifdef COM_RX_BYTE_COUNT_EN
        chk("count1", byte_count1, e.cnt);
`endif
      end
    end
  end

  initial begin
    logic [7:0] lock_seq [13] = '{8'hBC, 8'hBC, 8'hBC, 8'h12, 8'hBC, 8'hBC, 8'hBC, 8'hBC,
                                  8'h3A, 8'h01, 8'hBC, 8'hBC, 8'h02};
    // reset held with data 55
    step(1'b1, 8'h55);
    step(1'b1, 8'h55);
    // broken run, lock, first data, stripping and gaps
    foreach (lock_seq[i]) step(1'b0, lock_seq[i]);
    step(1'b0, 8'h03);
    // reset mid-stream, AA discarded, relock
    step(1'b1, 8'h44);
    step(1'b0, 8'hAA);
    repeat (4) step(1'b0, COM);
    step(1'b0, 8'h5A);
    // pre-lock data ignored
    step(1'b1, 8'h00);
    step(1'b0, 8'h77);
    step(1'b0, 8'h88);
    step(1'b0, 8'h99);
    // randomized stream with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) step(1'b1, rand_data());
      else if ($urandom_range(0, 99) < 55) step(1'b0, COM);
      else step(1'b0, rand_data());
    end
`ifdef COM_RX_BYTE_COUNT_EN
    step(1'b1, 8'h00);
    repeat (4) step(1'b0, COM);
    for (int i = 0; i < 65537; i++) step(1'b0, rand_data());
    @(posedge cclk);
    #1;
    chk("wrap0", byte_count0, 16'h0001);
    chk("wrap1", byte_count1, 16'h0001);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, COM);
      step(1'b0, rand_data());
    end
`endif
    repeat (3) @(posedge cclk);
    #2;
    chk("drain0", 16'(q0.size()), 16'd0);
    chk("drain1", 16'(q1.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
